// File: rtl/axi_pkg.sv
// Shared AXI definitions for the write master: burst encodings, FSM states
// and the 4KB page size that no burst may cross.
package axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam int BOUNDARY_4K = 4096;

endpackage

// File: rtl/axi_burst_len.sv
// Combinational burst sizer: min(remaining beats, MAX_LEN, beats left in the
// current 4KB page starting at the given page offset).
module axi_burst_len
    import axi_pkg::*;
#(
    parameter int DW      = 32,
    parameter int MAX_LEN = 16
) (
    input  logic [11:0] i_addr_ofs,
    input  logic [15:0] i_remaining,
    output logic [15:0] o_beats
);

    localparam int SZ = $clog2(DW / 8);

    logic [12:0] w_bytes_to_4k;
    logic [12:0] w_beats_to_4k;

    // Offset 0 yields a full page (4096 bytes), hence the 13-bit width.
    assign w_bytes_to_4k = 13'(BOUNDARY_4K) - {1'b0, i_addr_ofs};
    assign w_beats_to_4k = w_bytes_to_4k >> SZ;

    always_comb begin
        o_beats = 16'(MAX_LEN);
        if (16'(w_beats_to_4k) < o_beats) o_beats = 16'(w_beats_to_4k);
        if (i_remaining < o_beats)        o_beats = i_remaining;
    end

endmodule

// File: rtl/axi_wr_master.sv
// AXI4 write master: splits a (addr, beats) request into INCR bursts that
// respect MAX_LEN and 4KB pages, one burst outstanding at a time.
module axi_wr_master
    import axi_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_LEN = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic [AW-1:0]   i_req_addr,
    input  logic [15:0]     i_req_beats,
    input  logic            i_data_valid,
    output logic            o_data_ready,
    input  logic [DW-1:0]   i_data,
    output logic            o_awvalid,
    input  logic            i_awready,
    output logic [AW-1:0]   o_awaddr,
    output logic [7:0]      o_awlen,
    output logic [2:0]      o_awsize,
    output logic [1:0]      o_awburst,
    output logic            o_wvalid,
    input  logic            i_wready,
    output logic [DW-1:0]   o_wdata,
    output logic [DW/8-1:0] o_wstrb,
    output logic            o_wlast,
    input  logic            i_bvalid,
    output logic            o_bready,
    input  logic [1:0]      i_bresp,
    output logic            o_done,
    output logic            o_err,
    output logic [1:0]      o_state
);

    localparam int            SZ        = $clog2(DW / 8);
    localparam logic [AW-1:0] ADDR_MASK = ~AW'(DW / 8 - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_remaining;
    logic [15:0]   r_len;
    logic [15:0]   r_beat_cnt;
    logic          r_done;
    logic          r_err;
    logic [15:0]   w_len;
    logic          w_last;
    logic          w_more;
    logic          w_req_hs;
    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_b_hs;

    axi_burst_len #(
        .DW      (DW),
        .MAX_LEN (MAX_LEN)
    ) u_burst_len (
        .i_addr_ofs  (12'(r_addr)),
        .i_remaining (r_remaining),
        .o_beats     (w_len)
    );

    // Every channel transfers exactly on a clock edge where valid and ready
    // are both high; valids never depend on the matching ready.
    assign w_req_hs = o_req_ready & i_req_valid;
    assign w_aw_hs  = o_awvalid & i_awready;
    assign w_w_hs   = o_wvalid & i_wready;
    assign w_b_hs   = o_bready & i_bvalid;

    assign w_last = (r_beat_cnt == r_len - 16'd1);
    assign w_more = (r_remaining != r_len);

    always_comb begin
        w_next       = r_state;
        o_req_ready  = 1'b0;
        o_awvalid    = 1'b0;
        o_wvalid     = 1'b0;
        o_data_ready = 1'b0;
        o_wlast      = 1'b0;
        o_bready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid && i_req_beats != 16'd0) w_next = ST_ADDR;
            end
            ST_ADDR: begin
                o_awvalid = 1'b1;
                if (i_awready) w_next = ST_DATA;
            end
            ST_DATA: begin
                o_wvalid     = i_data_valid;
                o_data_ready = i_wready;
                o_wlast      = w_last;
                if (i_data_valid && i_wready && w_last) w_next = ST_RESP;
            end
            ST_RESP: begin
                o_bready = 1'b1;
                if (i_bvalid) w_next = w_more ? ST_ADDR : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_req_hs) begin
                r_addr      <= i_req_addr & ADDR_MASK;
                r_remaining <= i_req_beats;
                r_beat_cnt  <= '0;
                r_err       <= 1'b0;
                if (i_req_beats == 16'd0) r_done <= 1'b1;
            end
            if (w_aw_hs) r_len <= w_len;
            if (w_w_hs)  r_beat_cnt <= w_last ? 16'd0 : r_beat_cnt + 16'd1;
            // Errors are sticky for the request but never stop later bursts.
            if (w_b_hs) begin
                r_addr      <= r_addr + (AW'(r_len) << SZ);
                r_remaining <= r_remaining - r_len;
                if (i_bresp inside {2'b10, 2'b11}) r_err <= 1'b1;
                if (!w_more) r_done <= 1'b1;
            end
        end
    end

    assign o_awaddr  = r_addr;
    assign o_awlen   = 8'(w_len - 16'd1);
    assign o_awsize  = 3'(SZ);
    assign o_awburst = BURST_INCR;
    assign o_wdata   = i_data;
    assign o_wstrb   = '1;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_state   = r_state;

endmodule

// File: tb/tb_axi_wr_master.sv
// Self-checking bench for axi_wr_master: a randomised AXI slave/data source
// driven against a burst-splitting reference model and data scoreboard.
module tb_axi_wr_master;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_LEN = 16;
    localparam int BYTES   = DW / 8;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_req_valid = 1'b0;
    logic            o_req_ready;
    logic [AW-1:0]   i_req_addr = '0;
    logic [15:0]     i_req_beats = '0;
    logic            i_data_valid = 1'b0;
    logic            o_data_ready;
    logic [DW-1:0]   i_data = '0;
    logic            o_awvalid;
    logic            i_awready = 1'b0;
    logic [AW-1:0]   o_awaddr;
    logic [7:0]      o_awlen;
    logic [2:0]      o_awsize;
    logic [1:0]      o_awburst;
    logic            o_wvalid;
    logic            i_wready = 1'b0;
    logic [DW-1:0]   o_wdata;
    logic [DW/8-1:0] o_wstrb;
    logic            o_wlast;
    logic            i_bvalid = 1'b0;
    logic            o_bready;
    logic [1:0]      i_bresp = 2'b00;
    logic            o_done;
    logic            o_err;
    logic [1:0]      o_state;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: expected {wlast, wdata} per beat, plus expected AW list.
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] src_q[$];
    logic [AW-1:0] exp_aw_addr[$];
    logic [7:0]    exp_aw_len[$];
    logic [AW-1:0] obs_aw_addr[$];
    logic [7:0]    obs_aw_len[$];

    int   sb_bad, aw_unstable, hs_bad, done_cnt, err_after_bad, accept_cyc, done_cyc;
    bit   timed_out;
    logic done_err;

    axi_wr_master #(.AW(AW), .DW(DW), .MAX_LEN(MAX_LEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_beats(i_req_beats),
        .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data(i_data),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
        .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
        .o_wvalid(o_wvalid), .i_wready(i_wready), .o_wdata(o_wdata),
        .o_wstrb(o_wstrb), .o_wlast(o_wlast),
        .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
        .o_done(o_done), .o_err(o_err), .o_state(o_state)
    );

    // ---------------- clock ----------------
    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    task automatic build_model(input logic [AW-1:0] addr, input int beats);
        longint a;
        int rem, len, to4k, k;
        exp_q.delete(); src_q.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
        for (int i = 0; i < beats; i++) src_q.push_back(DW'($urandom));
        a   = longint'(addr) & ~longint'(BYTES - 1);
        rem = beats;
        k   = 0;
        while (rem > 0) begin
            to4k = int'((4096 - (a % 4096)) / BYTES);
            len  = rem;
            if (len > MAX_LEN) len = MAX_LEN;
            if (len > to4k) len = to4k;
            exp_aw_addr.push_back(a[AW-1:0]);
            exp_aw_len.push_back(8'(len - 1));
            for (int j = 0; j < len; j++) begin
                exp_q.push_back({(j == len - 1) ? 1'b1 : 1'b0, src_q[k]});
                k++;
            end
            a   = a + longint'(len * BYTES);
            rem = rem - len;
        end
    endtask

    // ---------------- driver: source + AXI slave, one request ----------------
    task automatic do_request(input logic [AW-1:0] addr, input int beats, input int aw_wait,
                              input int gap_pct, input int err_burst);
        int idx = 0, aw_cnt = 0, b_cnt = 0, b_dly = 0, b_idx = 0, cyc = 0, extra = 0;
        bit accepted = 0, b_owed = 0, aw_hold = 0;
        logic [AW-1:0] hold_addr = '0;
        logic [7:0]    hold_len = '0;
        logic [DW:0]   e;
        obs_aw_addr.delete(); obs_aw_len.delete();
        sb_bad = 0; aw_unstable = 0; hs_bad = 0; done_cnt = 0; err_after_bad = 0;
        accept_cyc = -1; done_cyc = -1; timed_out = 0; done_err = 1'bx;
        build_model(addr, beats);
        i_req_addr  = addr;
        i_req_beats = 16'(beats);
        while (1) begin
            @(negedge i_clk);
            i_req_valid  = !accepted;
            i_data_valid = ($urandom_range(99) >= gap_pct);
            i_data       = (idx < src_q.size()) ? src_q[idx] : DW'($urandom);
            i_wready     = ($urandom_range(99) >= gap_pct);
            i_awready    = (aw_cnt >= aw_wait);
            i_bvalid     = b_owed && (b_cnt >= b_dly);
            i_bresp      = (i_bvalid && b_idx == err_burst) ? 2'b10 : 2'b00;
            #1;
            if (i_req_valid && o_req_ready) begin accepted = 1; accept_cyc = cyc; end
            if (o_awvalid) begin
                if (aw_hold && (o_awaddr !== hold_addr || o_awlen !== hold_len)) aw_unstable++;
                if (i_awready) begin
                    obs_aw_addr.push_back(o_awaddr);
                    obs_aw_len.push_back(o_awlen);
                    aw_cnt = 0; aw_hold = 0;
                end else begin
                    aw_cnt++; aw_hold = 1; hold_addr = o_awaddr; hold_len = o_awlen;
                end
            end
            if ((o_wvalid && i_wready) !== (i_data_valid && o_data_ready)) hs_bad++;
            if (o_wvalid && i_wready) begin
                if (exp_q.size() == 0) sb_bad++;
                else begin
                    e = exp_q.pop_front();
                    if ({o_wlast, o_wdata} !== e) sb_bad++;
                end
                if (o_wlast) begin b_owed = 1; b_cnt = 0; b_dly = $urandom_range(2); end
            end
            if (i_data_valid && o_data_ready) idx++;
            if (i_bvalid && o_bready) begin b_owed = 0; b_idx++; end
            else if (b_owed) b_cnt++;
            if (o_done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; done_err = o_err; end
            end else if (done_cyc >= 0 && o_err !== done_err) err_after_bad++;
            if (done_cyc >= 0) extra++;
            cyc++;
            if (extra >= 4) break;
            if (cyc >= 3000) begin timed_out = 1; break; end
        end
        i_req_valid = 0; i_data_valid = 0; i_wready = 0; i_awready = 0; i_bvalid = 0; i_bresp = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst = 1;
        repeat (3) @(negedge i_clk);
        #1;
        n_checks++;
        if ({o_awvalid, o_wvalid, o_bready, o_data_ready, o_done, o_err} !== 6'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b, expected 000000",
                     {o_awvalid, o_wvalid, o_bready, o_data_ready, o_done, o_err});
        end
        @(negedge i_clk);
        i_rst = 0;
        @(negedge i_clk);
        #1;
        n_checks++;
        if (o_req_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_req_ready: got %b, expected 1", o_req_ready);
        end
        n_checks++;
        if (o_awaddr !== '0) begin
            n_errors++; $display("FAIL reset_addr: got %0h, expected 0", o_awaddr);
        end
    endtask

    task automatic test_single_burst();
        do_request(32'h0000, 4, 0, 0, -1);
        n_checks++;
        if (timed_out || obs_aw_addr.size() != 1) begin
            n_errors++; $display("FAIL single_aw_count: got %0d (timeout %0d), expected 1", obs_aw_addr.size(), timed_out);
        end else begin
            n_checks++;
            if (obs_aw_addr[0] !== 32'h0 || obs_aw_len[0] !== 8'd3) begin
                n_errors++; $display("FAIL single_aw: got %0h/%0d, expected 0/3", obs_aw_addr[0], obs_aw_len[0]);
            end
        end
        n_checks++;
        if (sb_bad != 0 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL single_beats: got %0d bad / %0d missing, expected 0/0", sb_bad, exp_q.size());
        end
        n_checks++;
        if (done_cnt != 1 || done_err !== 1'b0) begin
            n_errors++; $display("FAIL single_done: got done %0d err %b, expected 1/0", done_cnt, done_err);
        end
        n_checks++;
        if (o_awsize !== 3'd2 || o_awburst !== 2'b01 || o_wstrb !== 4'hF) begin
            n_errors++; $display("FAIL single_consts: got %0d/%0d/%0h, expected 2/1/f", o_awsize, o_awburst, o_wstrb);
        end
    endtask

    task automatic test_4k_split();
        logic [AW-1:0] want_addr[2] = '{32'h0FF8, 32'h1000};
        logic [7:0]    want_len[2]  = '{8'd1, 8'd5};
        do_request(32'h0FF8, 8, 0, 0, -1);
        n_checks++;
        if (timed_out || obs_aw_addr.size() != 2) begin
            n_errors++; $display("FAIL split4k_count: got %0d, expected 2", obs_aw_addr.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (obs_aw_addr[k] !== want_addr[k] || obs_aw_len[k] !== want_len[k]) begin
                    n_errors++; $display("FAIL split4k_aw%0d: got %0h/%0d, expected %0h/%0d",
                                         k, obs_aw_addr[k], obs_aw_len[k], want_addr[k], want_len[k]);
                end
                n_checks++;
                if ((obs_aw_addr[k] % 4096) + (obs_aw_len[k] + 1) * BYTES > 4096) begin
                    n_errors++; $display("FAIL split4k_cross%0d: got %0h/%0d, expected no 4KB crossing",
                                         k, obs_aw_addr[k], obs_aw_len[k]);
                end
            end
        end
        n_checks++;
        if (sb_bad != 0 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL split4k_beats: got %0d bad / %0d missing, expected 0/0", sb_bad, exp_q.size());
        end
    endtask

    task automatic test_max_len();
        logic [AW-1:0] want_addr[3] = '{32'h100, 32'h140, 32'h180};
        logic [7:0]    want_len[3]  = '{8'd15, 8'd15, 8'd7};
        do_request(32'h100, 40, 0, 10, -1);
        n_checks++;
        if (timed_out || obs_aw_addr.size() != 3) begin
            n_errors++; $display("FAIL maxlen_count: got %0d, expected 3", obs_aw_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (obs_aw_addr[k] !== want_addr[k] || obs_aw_len[k] !== want_len[k]) begin
                    n_errors++; $display("FAIL maxlen_aw%0d: got %0h/%0d, expected %0h/%0d",
                                         k, obs_aw_addr[k], obs_aw_len[k], want_addr[k], want_len[k]);
                end
            end
        end
        n_checks++;
        if (sb_bad != 0 || exp_q.size() != 0 || done_cnt != 1) begin
            n_errors++; $display("FAIL maxlen_beats: got %0d bad / %0d missing / %0d done, expected 0/0/1",
                                 sb_bad, exp_q.size(), done_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_request(32'h2040, 20, 5, 40, -1);
        n_checks++;
        if (timed_out || aw_unstable != 0) begin
            n_errors++; $display("FAIL bp_aw_stable: got %0d changes (timeout %0d), expected 0", aw_unstable, timed_out);
        end
        n_checks++;
        if (hs_bad != 0) begin
            n_errors++; $display("FAIL bp_passthrough: got %0d disagreements, expected 0", hs_bad);
        end
        n_checks++;
        if (sb_bad != 0 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL bp_beats: got %0d bad / %0d missing, expected 0/0", sb_bad, exp_q.size());
        end
        n_checks++;
        if (obs_aw_addr !== exp_aw_addr || obs_aw_len !== exp_aw_len) begin
            n_errors++; $display("FAIL bp_aw_list: got %0d bursts, expected %0d", obs_aw_addr.size(), exp_aw_addr.size());
        end
    endtask

    task automatic test_error_resp();
        do_request(32'h100, 40, 1, 20, 1);
        n_checks++;
        if (timed_out || obs_aw_addr.size() != 3) begin
            n_errors++; $display("FAIL err_bursts: got %0d, expected 3", obs_aw_addr.size());
        end
        n_checks++;
        if (done_cnt != 1 || done_err !== 1'b1) begin
            n_errors++; $display("FAIL err_done: got done %0d err %b, expected 1/1", done_cnt, done_err);
        end
        n_checks++;
        if (err_after_bad != 0) begin
            n_errors++; $display("FAIL err_held: got %0d drops, expected 0", err_after_bad);
        end
        n_checks++;
        if (sb_bad != 0 || exp_q.size() != 0) begin
            n_errors++; $display("FAIL err_beats: got %0d bad / %0d missing, expected 0/0", sb_bad, exp_q.size());
        end
    endtask

    task automatic test_zero_beats();
        do_request(32'h40, 0, 0, 0, -1);
        n_checks++;
        if (timed_out || obs_aw_addr.size() != 0) begin
            n_errors++; $display("FAIL zero_no_aw: got %0d bursts, expected 0", obs_aw_addr.size());
        end
        n_checks++;
        if (done_cyc != accept_cyc + 1 || done_cnt != 1) begin
            n_errors++; $display("FAIL zero_done: got done cycle %0d count %0d, expected %0d/1",
                                 done_cyc, done_cnt, accept_cyc + 1);
        end
        n_checks++;
        if (done_err !== 1'b0) begin
            n_errors++; $display("FAIL zero_err_cleared: got %b, expected 0", done_err);
        end
    endtask

    task automatic test_reset_mid_data();
        bit accepted = 0, seen = 0;
        @(negedge i_clk);
        i_req_addr = 32'h200; i_req_beats = 16'd8; i_req_valid = 1;
        i_awready = 1; i_wready = 0; i_data_valid = 1; i_data = 32'hDEADBEEF; i_bvalid = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (c > 0) @(negedge i_clk);
            if (accepted) i_req_valid = 0;
            #1;
            if (i_req_valid && o_req_ready) accepted = 1;
            if (o_wvalid) seen = 1;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_errors++; $display("FAIL rst_reach_data: got %b, expected 1", seen);
        end
        #2;
        i_rst = 1;
        i_wready = 1;
        #1;
        n_checks++;
        if ({o_awvalid, o_wvalid, o_data_ready, o_bready, o_done, o_err} !== 6'b0) begin
            n_errors++; $display("FAIL rst_mid_outputs: got %b, expected 000000",
                                 {o_awvalid, o_wvalid, o_data_ready, o_bready, o_done, o_err});
        end
        @(negedge i_clk);
        i_rst = 0; i_req_valid = 0; i_data_valid = 0; i_wready = 0; i_awready = 0;
        @(negedge i_clk);
        #1;
        n_checks++;
        if (o_req_ready !== 1'b1 || o_awaddr !== '0) begin
            n_errors++; $display("FAIL rst_mid_release: got ready %b addr %0h, expected 1/0", o_req_ready, o_awaddr);
        end
        do_request(32'h300, 6, 1, 20, -1);
        n_checks++;
        if (timed_out || sb_bad != 0 || exp_q.size() != 0 || done_cnt != 1 || done_err !== 1'b0) begin
            n_errors++; $display("FAIL rst_mid_recover: got bad %0d missing %0d done %0d err %b, expected 0/0/1/0",
                                 sb_bad, exp_q.size(), done_cnt, done_err);
        end
        n_checks++;
        if (obs_aw_addr !== exp_aw_addr || obs_aw_len !== exp_aw_len) begin
            n_errors++; $display("FAIL rst_mid_aw: got %0d bursts, expected %0d", obs_aw_addr.size(), exp_aw_addr.size());
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] addr;
        int beats, eb;
        logic want_err;
        for (int t = 0; t < 8; t++) begin
            addr  = AW'($urandom_range(0, 32'hFFFF));
            beats = $urandom_range(1, 70);
            eb    = int'($urandom_range(0, 4)) - 1;
            do_request(addr, beats, $urandom_range(0, 3), $urandom_range(0, 50), eb);
            want_err = (eb >= 0 && eb < exp_aw_addr.size()) ? 1'b1 : 1'b0;
            n_checks++;
            if (obs_aw_addr !== exp_aw_addr || obs_aw_len !== exp_aw_len) begin
                n_errors++; $display("FAIL rand%0d_aw: got %0d bursts, expected %0d (addr %0h beats %0d)",
                                     t, obs_aw_addr.size(), exp_aw_addr.size(), addr, beats);
            end
            n_checks++;
            if (timed_out || sb_bad != 0 || exp_q.size() != 0 || aw_unstable != 0 || hs_bad != 0) begin
                n_errors++; $display("FAIL rand%0d_data: got bad %0d missing %0d unstable %0d hs %0d, expected all 0",
                                     t, sb_bad, exp_q.size(), aw_unstable, hs_bad);
            end
            n_checks++;
            if (done_cnt != 1 || done_err !== want_err || err_after_bad != 0) begin
                n_errors++; $display("FAIL rand%0d_done: got done %0d err %b, expected 1/%b", t, done_cnt, done_err, want_err);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_burst();
        test_4k_split();
        test_max_len();
        test_backpressure();
        test_error_resp();
        test_zero_beats();
        test_reset_mid_data();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
